gpmc_burst_sram_ctrl: RTL
=========================

// Module: gpmc_burst_sram_ctrl
// PURPOSE
//  Parametrised GPMC synchronous, address/data-multiplexed slave that bridges
//  an ARM GPMC bus to an on-chip block RAM port.
//  Adds single and burst read/write support, per-byte write enables,
//  address auto-increment with optional wrap, and a configurable read latency.
//  The top level instantiates it between the AD IOBUF array and the BRAM.
// PARAMETERS
//  DATA_W      16  GPMC AD / RAM data width; multiple of 8 (8,16,32)
//  ADDR_W      11  RAM word-address width; ADDR_W <= DATA_W
//  BURST_LEN   4   wrap boundary in words; power of 2, 1..16
//  WRAP        0   1 = burst address wraps inside BURST_LEN block; 0 = linear
//  RD_LAT      1   RAM read latency in GPMC_CLK cycles (1..3)
// PORTS
//  GPMC_CLK     in   1           GPMC bus clock; all logic on rising edge
//  RST_N        in   1           async active-low reset
//  GPMC_AD_IN   in   DATA_W      AD bus from IOBUF O
//  GPMC_AD_OUT  out  DATA_W      AD bus to IOBUF I
//  GPMC_AD_OE   out  1           1 = drive AD (IOBUF T = ~GPMC_AD_OE)
//  GPMC_CS      in   1           chip select, active low
//  GPMC_ADV     in   1           address valid, active low
//  GPMC_OE      in   1           output enable, active low (read)
//  GPMC_WE      in   1           write enable, active low
//  GPMC_BE      in   DATA_W/8    byte enables, active low
//  GPMC_WAIT    out  1           wait to host, active high (GPMC_SRAM_WAIT_EN only)
//  a_ena        out  1           RAM port enable
//  a_wr         out  DATA_W/8    RAM byte write enables
//  a_addr       out  ADDR_W      RAM word address
//  a_din        out  DATA_W      RAM write data
//  a_dout       in   DATA_W      RAM read data
// BEHAVIOUR
//  Reset: state IDLE; GPMC_AD_OUT=0, GPMC_AD_OE=0, GPMC_WAIT=0, a_ena=0,
//   a_wr=0, a_addr=0, a_din=0; latency counter 0.
//  FSM: IDLE, WR, RD_LAT, RD.
//  IDLE: edge with CS=0 & ADV=0 latches addr <= GPMC_AD_IN[ADDR_W-1:0];
//   WE=0 -> WR; else RD_LAT with a_ena=1 at latched addr (read issued).
//  WR: each edge with CS=0 & WE=0: a_ena=1, a_wr=~GPMC_BE, a_din=AD_IN,
//   a_addr=addr; then addr increments. WE=1 in WR: no write, addr holds.
//  RD_LAT: counts RD_LAT cycles; issues read at addr+1 each cycle (prefetch);
//   -> RD when count hits RD_LAT. GPMC_AD_OE=0 throughout.
//  RD: GPMC_AD_OE = ~GPMC_OE (registered); GPMC_AD_OUT = a_dout, one word
//   per edge with OE=0; next read issued every edge, so throughput 1 word/clk.
//  Increment: WRAP=0 -> addr+1 mod 2^ADDR_W; WRAP=1 -> low log2(BURST_LEN)
//   bits increment mod BURST_LEN, upper bits fixed.
//  CS=1 at any edge: -> IDLE next cycle, a_ena=0, a_wr=0, GPMC_AD_OE=0;
//   in-flight read data discarded. CS=0 & ADV=0 in WR/RD re-latches address
//   (new transaction, no return through IDLE).
//  WE=0 & OE=0 simultaneously: write takes priority; AD_OE forced 0.
//  Bus turnaround: AD_OE deasserts the same edge OE rises; never drives
//   during address phase (ADV=0).
//  RST_N low mid-burst: immediate async return to reset values.
// CONFIGURATION
//  `GPMC_SRAM_WAIT_EN defined: GPMC_WAIT=1 from address latch through
//   RD_LAT state, 0 in RD and WR; host programmed for WAIT monitoring.
//  Undefined: GPMC_WAIT tied 0; host must use a fixed read access time
//   >= RD_LAT+1 cycles after ADV.
// STRUCTURE
//  Package gpmc_pkg: FSM state encoding constants (IDLE/WR/RD_LAT/RD),
//   BE_W = DATA_W/8 helper, next_addr function (WRAP/BURST_LEN aware).
//  Sub-module gpmc_burst_addr_gen: address register, load, increment/wrap.
//  FSM, read-latency counter and output registers stay in this module.
// TESTING
//  Single write: ADV addr 0x010, data 0xBEEF, BE=00 -> a_wr=11, a_addr=0x010.
//  Byte write: BE=10, data 0x1234 at 0x011 -> a_wr=01; readback 0x??34.
//  Burst write 4 words 0x100..0x103, WRAP=1 start 0x102 -> addrs 102,103,100,101.
//  Burst read RD_LAT=2 from 0x200: first valid AD 3 clks after ADV, then
//   one word/clk; WAIT=1 for 2 clks when GPMC_SRAM_WAIT_EN set.
//  CS rises mid burst read: AD_OE=0 next edge, a_ena=0, FSM IDLE.
//  RST_N pulse mid write burst: all outputs 0 asynchronously; next ADV works.

Source files
------------

// File: rtl/gpmc_pkg.sv
// Shared types and helpers for the GPMC burst SRAM bridge: FSM encoding,
// byte-lane width and the WRAP/BURST_LEN-aware address increment.
package gpmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR     = 2'd1,
        ST_RD_LAT = 2'd2,
        ST_RD     = 2'd3
    } state_t;

    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Linear increment modulo 2^addr_w, or increment of the low bits only inside a burst_len block.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input int unsigned addr_w,
                                              input int unsigned burst_len,
                                              input bit          wrap);
        logic [31:0] amask;
        logic [31:0] bmask;
        logic [31:0] inc;
        amask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        bmask = 32'(burst_len) - 32'd1;
        inc   = addr + 32'd1;
        if (wrap)
            return ((addr & ~bmask) | (inc & bmask)) & amask;
        return inc & amask;
    endfunction

endpackage

// File: rtl/gpmc_burst_addr_gen.sv
// Burst address register: loads on address phase, steps with linear or
// wrapping increment. addr_inc is the combinational successor of addr.
module gpmc_burst_addr_gen
    import gpmc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned WRAP      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_inc
);

    assign addr_inc = ADDR_W'(next_addr(32'(addr), ADDR_W, BURST_LEN, WRAP != 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (load)
            addr <= load_addr;
        else if (inc)
            addr <= addr_inc;
    end

endmodule

// File: rtl/gpmc_burst_sram_ctrl.sv
// GPMC synchronous AD-muxed slave bridging to a block RAM port, with burst
// read/write and fixed read latency. Optional host WAIT via GPMC_SRAM_WAIT_EN.
module gpmc_burst_sram_ctrl
    import gpmc_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned WRAP      = 0,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                  GPMC_CLK,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     GPMC_AD_IN,
    output logic [DATA_W-1:0]     GPMC_AD_OUT,
    output logic                  GPMC_AD_OE,
    input  logic                  GPMC_CS,
    input  logic                  GPMC_ADV,
    input  logic                  GPMC_OE,
    input  logic                  GPMC_WE,
    input  logic [DATA_W/8-1:0]   GPMC_BE,
    output logic                  GPMC_WAIT,
    output logic                  a_ena,
    output logic [DATA_W/8-1:0]   a_wr,
    output logic [ADDR_W-1:0]     a_addr,
    output logic [DATA_W-1:0]     a_din,
    input  logic [DATA_W-1:0]     a_dout
);

    localparam int unsigned BE_W  = be_w(DATA_W);
    localparam int unsigned CNT_W = 2;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
    logic [ADDR_W-1:0]   addr, addr_inc;
    logic                addr_load, addr_step;

    logic [DATA_W-1:0]   ad_out_next;
    logic                ad_oe_next, wait_next, a_ena_next;
    logic [BE_W-1:0]     a_wr_next;
    logic [ADDR_W-1:0]   a_addr_next;
    logic [DATA_W-1:0]   a_din_next;

    assign cnt_inc = cnt + CNT_W'(1);

    gpmc_burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .WRAP      (WRAP)
    ) u_addr_gen (
        .clk       (GPMC_CLK),
        .rst_n     (RST_N),
        .load      (addr_load),
        .load_addr (GPMC_AD_IN[ADDR_W-1:0]),
        .inc       (addr_step),
        .addr      (addr),
        .addr_inc  (addr_inc)
    );

    always_ff @(posedge GPMC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Address phase (CS=0, ADV=0) restarts from any state; CS high always returns to IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (GPMC_CS) begin
            state_next = ST_IDLE;
        end else if (!GPMC_ADV) begin
            state_next = GPMC_WE ? ST_RD_LAT : ST_WR;
        end else if (state == ST_RD_LAT) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_W'(RD_LAT))
                state_next = ST_RD;
        end
    end

    always_comb begin
        ad_out_next = GPMC_AD_OUT;
        ad_oe_next  = 1'b0;
        a_ena_next  = 1'b0;
        a_wr_next   = '0;
        a_addr_next = a_addr;
        a_din_next  = a_din;
        addr_load   = 1'b0;
        addr_step   = 1'b0;
        if (!GPMC_CS) begin
            if (!GPMC_ADV) begin
                addr_load = 1'b1;
                if (GPMC_WE) begin
                    a_ena_next  = 1'b1;
                    a_addr_next = GPMC_AD_IN[ADDR_W-1:0];
                end
            end else begin
                case (state)
                    ST_WR: begin
                        if (!GPMC_WE) begin
                            a_ena_next  = 1'b1;
                            a_wr_next   = ~GPMC_BE;
                            a_din_next  = GPMC_AD_IN;
                            a_addr_next = addr;
                            addr_step   = 1'b1;
                        end
                    end
                    ST_RD_LAT: begin
                        a_ena_next  = 1'b1;
                        a_addr_next = addr_inc;
                        addr_step   = 1'b1;
                    end
                    ST_RD: begin
                        a_ena_next  = 1'b1;
                        a_addr_next = addr_inc;
                        addr_step   = 1'b1;
                        ad_out_next = a_dout;
                        ad_oe_next  = GPMC_WE && !GPMC_OE;
                    end
                    default: ;
                endcase
            end
        end
`ifdef GPMC_SRAM_WAIT_EN
        wait_next = (state_next == ST_RD_LAT);
`else
        wait_next = 1'b0;
`endif
    end

    always_ff @(posedge GPMC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            GPMC_AD_OUT <= '0;
            GPMC_AD_OE  <= 1'b0;
            GPMC_WAIT   <= 1'b0;
            a_ena       <= 1'b0;
            a_wr        <= '0;
            a_addr      <= '0;
            a_din       <= '0;
        end else begin
            GPMC_AD_OUT <= ad_out_next;
            GPMC_AD_OE  <= ad_oe_next;
            GPMC_WAIT   <= wait_next;
            a_ena       <= a_ena_next;
            a_wr        <= a_wr_next;
            a_addr      <= a_addr_next;
            a_din       <= a_din_next;
        end
    end

endmodule
